// File: rtl/modn_updown_counter.sv
// modn_updown_counter: runtime-programmable mod-N up/down counter.
// Counts within 0..mod-1 with a loadable modulus, direction control, enable,
// synchronous preset, combinational cascade carry (tc) and a registered wrap pulse.
// Optional feature: define MODN_CNT_SATURATE_EN to enable saturate mode (sat input);
// without it sat is ignored and sat_flag is tied low.
module modn_updown_counter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned N_DEFAULT = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mod_wr,
  input  logic [WIDTH-1:0] mod_val,
  input  logic             sat,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] mod,
  output logic             tc,
  output logic             wrap,
  output logic             err,
  output logic             sat_flag
);

  logic [WIDTH-1:0] last;
  logic             at_top;
  logic             at_bottom;
  logic             at_term;
  logic             sat_mode;

  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] mod_next;
  logic             wrap_next;
  logic             err_next;
  logic             sat_set;
  logic             sat_clr;

  assign last      = mod - WIDTH'(1);
  assign at_top    = (q == last);
  assign at_bottom = (q == '0);
  assign at_term   = up ? at_top : at_bottom;

  // Carry for cascading: only meaningful when this stage is actually stepping.
  assign tc = en & ~reset & at_term;

`ifdef MODN_CNT_SATURATE_EN
  assign sat_mode = sat;
`else
  assign sat_mode = sat & 1'b0;
`endif

  // Next-state selection with priority mod_wr > load > en.
  always_comb begin
    q_next    = q;
    mod_next  = mod;
    wrap_next = 1'b0;
    err_next  = 1'b0;
    sat_set   = 1'b0;
    sat_clr   = 1'b0;
    if (mod_wr) begin
      if (mod_val < WIDTH'(2)) begin
        err_next = 1'b1;
      end else begin
        mod_next = mod_val;
        sat_clr  = 1'b1;
        if (q >= mod_val) begin
          q_next = '0;
        end
      end
    end else if (load) begin
      if (load_val < mod) begin
        q_next  = load_val;
        sat_clr = 1'b1;
      end else begin
        err_next = 1'b1;
      end
    end else if (en) begin
      if (at_term) begin
        if (sat_mode) begin
          sat_set = 1'b1;
        end else begin
          wrap_next = 1'b1;
          q_next    = up ? '0 : last;
        end
      end else begin
        q_next = up ? (q + WIDTH'(1)) : (q - WIDTH'(1));
      end
    end
  end

  // Count, modulus and single-cycle status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q    <= '0;
      mod  <= WIDTH'(N_DEFAULT);
      wrap <= 1'b0;
      err  <= 1'b0;
    end else begin
      q    <= q_next;
      mod  <= mod_next;
      wrap <= wrap_next;
      err  <= err_next;
    end
  end

`ifdef MODN_CNT_SATURATE_EN
  // Sticky saturation flag; a successful write clears it in preference to setting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_flag <= 1'b0;
    end else if (sat_clr) begin
      sat_flag <= 1'b0;
    end else if (sat_set) begin
      sat_flag <= 1'b1;
    end
  end
`else
  logic unused_sat_ctl;
  assign unused_sat_ctl = sat_set | sat_clr;
  assign sat_flag       = unused_sat_ctl & 1'b0;
`endif

endmodule

// File: tb/tb_modn_updown_counter.sv
// Testbench for modn_updown_counter: scoreboard of predicted register values
// against a behavioural model, plus a two-stage cascade check.
module tb_modn_updown_counter;

  localparam int unsigned W = 8;
`ifdef MODN_CNT_SATURATE_EN
  localparam bit SAT_BUILD = 1'b1;
`else
  localparam bit SAT_BUILD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b0, up = 1'b1, load = 1'b0, mod_wr = 1'b0, sat = 1'b0;
  logic [W-1:0] load_val = '0, mod_val = '0;
  logic [W-1:0] q, mod;
  logic         tc, wrap, err, sat_flag;

  // cascade pair
  logic         c_en = 1'b0, c_mod_wr = 1'b0;
  logic [W-1:0] c_mod_val = '0;
  logic [W-1:0] lo_q, lo_mod, hi_q, hi_mod;
  logic         lo_tc, lo_wrap, lo_err, lo_sf, hi_tc, hi_wrap, hi_err, hi_sf;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] mod;
    logic         wrap;
    logic         err;
    logic         sat_flag;
  } exp_t;
  exp_t sb[$];

  logic [W-1:0] m_q, m_mod;
  logic         m_sat;

  always #5 clk = ~clk;

  modn_updown_counter #(.WIDTH(W), .N_DEFAULT(12)) dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .mod_wr(mod_wr), .mod_val(mod_val), .sat(sat), .q(q), .mod(mod), .tc(tc),
    .wrap(wrap), .err(err), .sat_flag(sat_flag)
  );

  modn_updown_counter #(.WIDTH(W), .N_DEFAULT(12)) u_lo (
    .clk(clk), .reset(reset), .en(c_en), .up(1'b1), .load(1'b0), .load_val('0),
    .mod_wr(c_mod_wr), .mod_val(c_mod_val), .sat(1'b0), .q(lo_q), .mod(lo_mod),
    .tc(lo_tc), .wrap(lo_wrap), .err(lo_err), .sat_flag(lo_sf)
  );

  modn_updown_counter #(.WIDTH(W), .N_DEFAULT(12)) u_hi (
    .clk(clk), .reset(reset), .en(lo_tc), .up(1'b1), .load(1'b0), .load_val('0),
    .mod_wr(c_mod_wr), .mod_val(c_mod_val), .sat(1'b0), .q(hi_q), .mod(hi_mod),
    .tc(hi_tc), .wrap(hi_wrap), .err(hi_err), .sat_flag(hi_sf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of stimulus: drive, check tc, predict next state, compare after the edge.
  task automatic step(input logic e, input logic u, input logic l, input logic [W-1:0] lv,
                      input logic mw, input logic [W-1:0] mv, input logic s);
    exp_t nx;
    exp_t got;
    logic term;
    logic smode;
    @(negedge clk);
    en = e; up = u; load = l; load_val = lv; mod_wr = mw; mod_val = mv; sat = s;
    #1;
    term  = u ? (m_q + 8'd1 == m_mod) : (m_q == 8'd0);
    smode = SAT_BUILD && s;
    check("tc", tc, e && term);
    nx.q = m_q; nx.mod = m_mod; nx.wrap = 1'b0; nx.err = 1'b0; nx.sat_flag = m_sat;
    if (mw) begin
      if (mv <= 8'd1) nx.err = 1'b1;
      else begin
        nx.mod = mv;
        nx.sat_flag = 1'b0;
        if (m_q >= mv) nx.q = 8'd0;
      end
    end else if (l) begin
      if (lv < m_mod) begin
        nx.q = lv;
        nx.sat_flag = 1'b0;
      end else nx.err = 1'b1;
    end else if (e) begin
      if (term && smode) nx.sat_flag = 1'b1;
      else if (term) begin
        nx.wrap = 1'b1;
        nx.q = u ? 8'd0 : m_mod - 8'd1;
      end else nx.q = u ? m_q + 8'd1 : m_q - 8'd1;
    end
    sb.push_back(nx);
    m_q = nx.q; m_mod = nx.mod; m_sat = nx.sat_flag;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      got = sb.pop_front();
      check("q", q, got.q);
      check("mod", mod, got.mod);
      check("wrap", wrap, got.wrap);
      check("err", err, got.err);
      check("sat_flag", sat_flag, got.sat_flag);
      check("q_in_range", (q < mod), 1);
    end
  endtask

  task automatic run(input int n, input logic u, input logic s);
    for (int i = 0; i < n; i++) step(1'b1, u, 1'b0, '0, 1'b0, '0, s);
  endtask

  task automatic do_load(input logic [W-1:0] v);
    step(1'b0, 1'b1, 1'b1, v, 1'b0, '0, 1'b0);
  endtask

  task automatic do_mod(input logic [W-1:0] v);
    step(1'b0, 1'b1, 1'b0, '0, 1'b1, v, 1'b0);
  endtask

  initial begin
    m_q = '0; m_mod = 8'd12; m_sat = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_q", q, 0);
    check("rst_mod", mod, 12);
    check("rst_wrap", wrap, 0);
    check("rst_err", err, 0);
    check("rst_sat_flag", sat_flag, 0);
    check("rst_tc", tc, 0);
    @(negedge clk);
    reset = 1'b0;

    // up count over two full periods, then down count through wraps
    run(26, 1'b1, 1'b0);
    do_load(8'd0);
    run(14, 1'b0, 1'b0);

    // modulus shrink below current count, then rejected modulus
    do_load(8'd9);
    do_mod(8'd5);
    do_mod(8'd1);
    do_mod(8'd0);

    // load accept / reject, and priority of mod_wr over load
    do_load(8'd3);
    do_load(8'd7);
    step(1'b1, 1'b1, 1'b1, 8'd6, 1'b1, 8'd8, 1'b0);
    step(1'b1, 1'b1, 1'b1, 8'd2, 1'b0, 8'd0, 1'b0);

    // mod = 2 toggling, and growing the modulus keeps q
    do_mod(8'd2);
    run(5, 1'b1, 1'b0);
    do_load(8'd1);
    do_mod(8'd200);
    do_mod(8'd255);
    run(3, 1'b0, 1'b0);

    // saturate mode (ignored unless the feature is built in)
    do_mod(8'd4);
    do_load(8'd0);
    run(6, 1'b1, 1'b1);
    do_load(8'd0);
    run(3, 1'b0, 1'b1);
    do_load(8'd2);
    run(3, 1'b1, 1'b1);
    do_mod(8'd6);

    // random mixed traffic
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
           8'($urandom_range(0, 20)), $urandom_range(0, 15) == 0, 8'($urandom_range(0, 20)),
           1'($urandom_range(0, 1)));
    end

    // asynchronous reset mid-count
    do_mod(8'd12);
    do_load(8'd2);
    @(negedge clk);
    en = 1'b1; up = 1'b0; load = 1'b0; mod_wr = 1'b0; sat = 1'b0;
    #1;
    up = 1'b1;
    reset = 1'b1;
    #1;
    check("async_q", q, 0);
    check("async_mod", mod, 12);
    check("async_wrap", wrap, 0);
    check("async_err", err, 0);
    check("async_sat_flag", sat_flag, 0);
    up = 1'b0;
    #1;
    check("async_tc", tc, 0);
    @(posedge clk);
    #1;
    check("hold_q", q, 0);
    @(negedge clk);
    reset = 1'b0;
    en = 1'b0;
    m_q = '0; m_mod = 8'd12; m_sat = 1'b0;
    run(2, 1'b1, 1'b0);

    // cascade: two mod-10 stages form a 00..99 counter
    @(negedge clk);
    c_mod_wr = 1'b1; c_mod_val = 8'd10;
    @(negedge clk);
    c_mod_wr = 1'b0;
    #1;
    check("c_lo_mod", lo_mod, 10);
    check("c_hi_mod", hi_mod, 10);
    c_en = 1'b1;
    for (int i = 0; i < 105; i++) begin
      #1;
      check("c_value", hi_q * 10 + lo_q, i % 100);
      check("c_lo_tc", lo_tc, (i % 10) == 9);
      check("c_hi_tc", hi_tc, (i % 100) == 99);
      @(negedge clk);
    end
    c_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
